// File: rtl/lane_merge_pkg.sv
// Shared types and default sizing for the lane merge FIFO slice.
package lane_merge_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_e;

  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_DEF      = 8;
  localparam int CNT_W_DEF      = 8;
  localparam int LANE_VALID_BIT = DATA_W_DEF;
  localparam int PTR_W_DEF      = $clog2(DEPTH_DEF);

endpackage

// File: rtl/dual_push_fifo.sv
// Synchronous FIFO with two ordered write ports (wr0 lands before wr1) and one read port.
// The head is registered so it holds its last value while the FIFO is empty.
module dual_push_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr0_en_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] head_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr1_ptr, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;

  assign wr1_ptr  = wr_ptr_q + PTR_W'(1);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
  assign occ_d    = occ_q + OCC_W'(wr0_en_i) + OCC_W'(wr1_en_i) - OCC_W'(rd_en_i);

  // Next head may be a word written this very cycle when the FIFO runs dry.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    head_d = head_q;
    if (occ_d != '0) begin
      if (wr0_en_i && wr_ptr_q == rd_ptr_d)      head_d = wr0_data_i;
      else if (wr1_en_i && wr1_ptr == rd_ptr_d)  head_d = wr1_data_i;
      else                                       head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: storage has no reset; pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wr_ptr_q] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_ptr]  <= wr1_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
    end
  end

  assign head_o      = head_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/lane_merge_fifo.sv
// Merges two tagged lanes into one ordered stream, buffers it and frames it by word count.
// Optional lane alternation checking is enabled with LANE_MERGE_ORDER_CHECK_EN.
module lane_merge_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W:0]   lane0_in,
  input  logic [DATA_W:0]   lane1_in,
  input  logic [CNT_W-1:0]  frame_max,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              overflow,
  output logic              frame_done,
  output logic [CNT_W-1:0]  word_count,
  output logic              order_err
);

  localparam int VALID_BIT = DATA_W;
  localparam int OCC_W     = $clog2(DEPTH) + 1;

  state_e            state_q;
  logic [CNT_W-1:0]  max_q, word_count_q, count_d, limit, remaining;
  logic              overflow_q, frame_done_q;
  logic [OCC_W-1:0]  occ, free_ent;
  logic              v0, v1, accepting, pop, drop;
  logic [1:0]        n_acc;
  logic [DATA_W-1:0] wr0_data;

  assign v0        = lane0_in[VALID_BIT];
  assign v1        = lane1_in[VALID_BIT];
  assign accepting = (state_q == FILL) || (state_q == IDLE && frame_max != '0);
  assign limit     = (state_q == IDLE) ? frame_max : max_q;
  assign remaining = limit - word_count_q;
  assign free_ent  = OCC_W'(DEPTH) - occ;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign count_d   = word_count_q + CNT_W'(n_acc);
  // A lone lane1 word travels through write port 0 so wr1 always implies wr0.
  assign wr0_data  = v0 ? lane0_in[DATA_W-1:0] : lane1_in[DATA_W-1:0];

  always_comb begin
    n_acc = 2'd0;
    drop  = 1'b0;
    if (accepting) begin
      if (remaining == '0) begin
        drop = v0 | v1;
      end else if (v0 && v1) begin
        if (remaining == CNT_W'(1)) begin
          n_acc = 2'd1;
          drop  = 1'b1;
        end else begin
          n_acc = 2'd2;
        end
      end else if (v0 || v1) begin
        n_acc = 2'd1;
      end
      // All-or-nothing: space is judged before this cycle's pop.
      if (OCC_W'(n_acc) > free_ent) begin
        n_acc = 2'd0;
        drop  = 1'b1;
      end
    end else if (state_q == DRAIN) begin
      drop = v0 | v1;
    end
  end

  dual_push_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr0_en_i    (n_acc != 2'd0),
    .wr0_data_i  (wr0_data),
    .wr1_en_i    (n_acc == 2'd2),
    .wr1_data_i  (lane1_in[DATA_W-1:0]),
    .rd_en_i     (pop),
    .head_o      (out_data),
    .occupancy_o (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      max_q        <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          max_q        <= frame_max;
          word_count_q <= count_d;
          if (n_acc != 2'd0) state_q <= FILL;
        end
        FILL: begin
          word_count_q <= count_d;
          if (count_d >= max_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (occ == '0) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          word_count_q <= '0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign full       = (occ > OCC_W'(DEPTH - 2));
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;
  assign word_count = word_count_q;

`ifdef LANE_MERGE_ORDER_CHECK_EN
  logic exp_lane_q, exp_lane, order_err_q;

  // Every frame starts expecting lane0.
  assign exp_lane = (state_q == IDLE) ? 1'b0 : exp_lane_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_lane_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else if (accepting) begin
      if (v0 && v1) begin
        order_err_q <= 1'b1;
        exp_lane_q  <= 1'b0;
      end else if (v0 || v1) begin
        if (v1 != exp_lane) order_err_q <= 1'b1;
        exp_lane_q <= ~v1;
      end
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_merge_fifo.sv
// Self-checking bench for lane_merge_fifo: directed frames plus random traffic against a queue model.
module tb_lane_merge_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W:0]   lane0_in, lane1_in;
  logic [CNT_W-1:0]  frame_max;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready, full, overflow, frame_done, order_err;
  logic [CNT_W-1:0]  word_count;

  always #5 clk = ~clk;

  lane_merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .lane0_in   (lane0_in),
    .lane1_in   (lane1_in),
    .frame_max  (frame_max),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .overflow   (overflow),
    .frame_done (frame_done),
    .word_count (word_count),
    .order_err  (order_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame phase (0 idle, 1 fill, 2 drain, 3 done), a word queue and flags.
  int                ph;
  int                m_max, m_cnt, m_exp;
  bit                m_ovf, m_done, m_oerr;
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_last;

  task automatic model_reset();
    q.delete();
    ph = 0; m_max = 0; m_cnt = 0; m_exp = 0;
    m_ovf = 0; m_done = 0; m_oerr = 0; m_last = '0;
  endtask

  task automatic model_step();
    bit v0 = lane0_in[DATA_W];
    bit v1 = lane1_in[DATA_W];
    logic [DATA_W-1:0] words[$];
    int pre  = q.size();
    int free = DEPTH - pre;
    bit acc  = (ph == 1) || (ph == 0 && frame_max != 0);
    int lim  = (ph == 0) ? int'(frame_max) : m_max;
    int rem  = lim - m_cnt;
    m_done = 0;
    if (acc) begin
      if (v0) words.push_back(lane0_in[DATA_W-1:0]);
      if (v1) words.push_back(lane1_in[DATA_W-1:0]);
      if (words.size() > rem) begin
        m_ovf = 1;
        while (words.size() > rem) void'(words.pop_back());
      end
      if (words.size() > free) begin
        m_ovf = 1;
        words.delete();
      end
`ifdef LANE_MERGE_ORDER_CHECK_EN
      if (v0 && v1) begin
        m_oerr = 1;
        m_exp  = 0;
      end else if (v0 || v1) begin
        if (int'(v1) != ((ph == 0) ? 0 : m_exp)) m_oerr = 1;
        m_exp = v1 ? 0 : 1;
      end
`endif
    end else if (ph == 2 && (v0 || v1)) begin
      m_ovf = 1;
    end
    if (pre > 0 && out_ready) void'(q.pop_front());
    foreach (words[i]) q.push_back(words[i]);
    m_cnt += words.size();
    if (q.size() > 0) m_last = q[0];
    case (ph)
      0: begin m_max = frame_max; if (words.size() > 0) ph = 1; end
      1: if (m_cnt >= m_max) ph = 2;
      2: if (pre == 0) begin ph = 3; m_done = 1; end
      default: begin m_cnt = 0; ph = 0; end
    endcase
  endtask

  task automatic cycle(input string tag);
    if (!reset) model_reset();
    else        model_step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) done_seen++;
    check({tag, ".valid"}, out_valid, q.size() != 0);
    check({tag, ".data"},  out_data,  m_last);
    check({tag, ".full"},  full,      q.size() > DEPTH - 2);
    check({tag, ".ovf"},   overflow,  m_ovf);
    check({tag, ".done"},  frame_done, m_done);
    check({tag, ".count"}, word_count, m_cnt);
    check({tag, ".oerr"},  order_err, m_oerr);
  endtask

  task automatic set_lanes(input bit v0, input logic [DATA_W-1:0] d0,
                           input bit v1, input logic [DATA_W-1:0] d1);
    lane0_in = {v0, d0};
    lane1_in = {v1, d1};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_lanes(0, '0, 0, '0);
    cycle("rst");
    reset = 1'b1;
  endtask

  int d0_mark;

  initial begin
    reset = 1'b0; out_ready = 1'b0; frame_max = '0;
    set_lanes(0, '0, 0, '0);
    repeat (2) cycle("rst");
    check("rst.word_count", word_count, 0);
    check("rst.out_data", out_data, 0);
    reset = 1'b1;

    // Alternating lanes, consumer always ready.
    frame_max = 4; out_ready = 1'b1; d0_mark = done_seen;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) set_lanes(1, 16'hA001 + 16'(i), 0, '0);
      else            set_lanes(0, '0, 1, 16'hA001 + 16'(i));
      cycle("alt");
    end
    set_lanes(0, '0, 0, '0);
    repeat (6) cycle("alt");
    check("alt.done_pulses", done_seen - d0_mark, 1);
    check("alt.overflow", overflow, 0);

    // Dual-valid words held back, then drained lane0-first.
    do_reset();
    frame_max = 6; out_ready = 1'b0; d0_mark = done_seen;
    for (int i = 0; i < 3; i++) begin
      set_lanes(1, 16'hB000 + 16'(2 * i), 1, 16'hB001 + 16'(2 * i));
      cycle("dual");
    end
    set_lanes(0, '0, 0, '0);
    repeat (2) cycle("dual");
    check("dual.head", out_data, 16'hB000);
    out_ready = 1'b1;
    repeat (10) cycle("dual");
    check("dual.done_pulses", done_seen - d0_mark, 1);

    // Capacity overflow: fifth dual cycle finds no room.
    do_reset();
    frame_max = 20; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lanes(1, 16'hC000 + 16'(2 * i), 1, 16'hC001 + 16'(2 * i));
      cycle("cap");
    end
    check("cap.word_count", word_count, 8);
    check("cap.overflow", overflow, 1);
    check("cap.full", full, 1);

    // Reset in the middle of a frame with words buffered.
    do_reset();
    frame_max = 10; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lanes(1, 16'hD000 + 16'(i), 0, '0);
      cycle("midrst");
    end
    check("midrst.before", out_valid, 1);
    do_reset();
    check("midrst.valid", out_valid, 0);
    check("midrst.count", word_count, 0);
    check("midrst.ovf", overflow, 0);

    // Budget of one word left with both lanes valid.
    frame_max = 3;
    set_lanes(1, 16'hE001, 0, '0);      cycle("budget");
    set_lanes(0, '0, 1, 16'hE002);      cycle("budget");
    set_lanes(1, 16'hE003, 1, 16'hE004); cycle("budget");
    check("budget.count", word_count, 3);
    check("budget.ovf", overflow, 1);
    set_lanes(0, '0, 0, '0);
    out_ready = 1'b1;
    repeat (8) cycle("budget");

    // Lane order: lane1 twice from the start of a frame.
    do_reset();
    frame_max = 5; out_ready = 1'b1;
    set_lanes(0, '0, 1, 16'hF001); cycle("order");
`ifdef LANE_MERGE_ORDER_CHECK_EN
    check("order.first", order_err, 1);
`else
    check("order.first", order_err, 0);
`endif
    set_lanes(0, '0, 1, 16'hF002); cycle("order");
`ifdef LANE_MERGE_ORDER_CHECK_EN
    check("order.sticky", order_err, 1);
`else
    check("order.sticky", order_err, 0);
`endif

    // Random traffic with occasional resets and frame length changes.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 97 == 0) frame_max = CNT_W'($urandom_range(0, 14));
      reset     = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_lanes($urandom_range(0, 1) == 1, DATA_W'($urandom),
                $urandom_range(0, 2) == 0, DATA_W'($urandom));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
